// File: rtl/shiftin_rx_if.sv
// Three-wire latch/clock/data shift link plus the receiver's parallel result port.
// The master side drives the serial wires; the slave side is the receiver.
interface shiftin_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  SHIFT_LATCH;
    logic                  SHIFT_CLOCK;
    logic                  SHIFT_DATA;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  frame_error;
    logic                  busy;

    modport master (
        output SHIFT_LATCH, SHIFT_CLOCK, SHIFT_DATA,
        input  data_out, data_valid, frame_error, busy
    );

    modport slave (
        input  SHIFT_LATCH, SHIFT_CLOCK, SHIFT_DATA,
        output data_out, data_valid, frame_error, busy
    );
endinterface

// File: rtl/shiftin_rx.sv
// Serial-in, parallel-out receiver: oversamples the shift wires on ICE_CLK,
// assembles words MSB-first and commits them on a latch rise.
module shiftin_rx #(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        ICE_CLK,
    input  logic        RST_N,
    shiftin_rx_if.slave bus
);
    localparam int CNT_W  = $clog2(DATA_WIDTH + 2);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int MASK_W = $clog2(SYNC_STAGES + 2);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DATA_WIDTH + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MASK_W-1:0] MASK_DONE = MASK_W'(SYNC_STAGES + 1);

    localparam int PIN_CLK = 0;
    localparam int PIN_LAT = 1;
    localparam int PIN_DAT = 2;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [2:0]                  pins;
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  synced;
    logic [2:0]                  hist_q;
    logic [MASK_W-1:0]           mask_q;
    logic                        edge_en;
    logic                        clk_rise_q;
    logic                        lat_rise_q;

    assign pins    = {bus.SHIFT_DATA, bus.SHIFT_LATCH, bus.SHIFT_CLOCK};
    assign synced  = sync_q[SYNC_STAGES-1];
    assign edge_en = (mask_q == MASK_DONE);

    // Rises are registered so a data bit is taken from the history flop,
    // i.e. the data sample aligned with the clock sample that rose.
    always_ff @(posedge ICE_CLK) begin
        if (!RST_N) begin
            sync_q     <= '0;
            hist_q     <= '0;
            mask_q     <= '0;
            clk_rise_q <= 1'b0;
            lat_rise_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts one stage per clock.
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pins};
            hist_q     <= synced;
            clk_rise_q <= edge_en & synced[PIN_CLK] & ~hist_q[PIN_CLK];
            lat_rise_q <= edge_en & synced[PIN_LAT] & ~hist_q[PIN_LAT];
            if (mask_q != MASK_DONE) begin
                mask_q <= mask_q + 1'b1;
            end
        end
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_eff;
    logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_eff;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    always_ff @(posedge ICE_CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            tmo_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            tmo_q   <= tmo_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // A clock rise in the same cycle as a latch rise is folded in before the frame is judged.
    assign sr_eff  = clk_rise_q ? {sr_q[DATA_WIDTH-2:0], hist_q[PIN_DAT]} : sr_q;
    assign cnt_eff = !clk_rise_q       ? cnt_q   :
                     (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every target gets a default first so no path through the case leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        tmo_d   = tmo_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                if (clk_rise_q) begin
                    sr_d    = sr_eff;
                    cnt_d   = cnt_eff;
                    tmo_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_eff;
                cnt_d = cnt_eff;
                if (lat_rise_q) begin
                    if (cnt_eff == CNT_FULL) begin
                        dout_d  = sr_eff;
                        valid_d = 1'b1;
                        ferr_d  = 1'b0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else if (clk_rise_q) begin
                    tmo_d = '0;
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    sr_d    = '0;
                    state_d = IDLE;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.data_out    = dout_q;
        bus.data_valid  = valid_q;
        bus.frame_error = ferr_q;
        bus.busy        = (state_q == SHIFT);
    end
endmodule
